// File: rtl/wb_frame_tx.sv
// Wishbone-classic slave: queues FRAME_W-bit words in a FIFO and serialises
// each as a frame on data_o (framed by ena_o), with programmable bit period and order.
module wb_frame_tx #(
  parameter int FRAME_W    = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 3,
  parameter int GAP_BITS   = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ena_o,
  output logic        data_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic               acc;
  logic               wr;
  logic [1:0]         sel;
  logic [31:0]        rdata;
  logic [31:0]        status;

  logic               en;
  logic               msb;
  logic [DIV_W-1:0]   div;
  logic               ovf;

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        level;
  logic               empty;
  logic               full;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               flush;
  logic               ovf_set;
  logic               ovf_clr;

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [BW-1:0]      bitcnt;
  logic [DIV_W-1:0]   divcnt;
  logic [DIV_W-1:0]   div_lat;
  logic               msb_lat;
  logic [3:0]         gapcnt;
  logic               cur_bit;

  logic               unused_bits;
  assign unused_bits = ^{ADR_I, DAT_I};

  // Register access happens on the same edge that raises ACK_O.
  assign acc = CYC_I & STB_I & ~ACK_O;
  assign wr  = acc & WE_I;
  assign sel = ADR_I[3:2];

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign pop      = (state == S_IDLE) & en & ~empty;
  assign push_req = wr & (sel == A_DATA);
  assign push_ok  = push_req & (~full | pop);
  assign flush    = wr & (sel == A_CTRL) & DAT_I[2];
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr & (sel == A_STATUS) & DAT_I[3];

  always_comb begin
    status = '0;
    status[0] = (state != S_IDLE);
    status[1] = empty;
    status[2] = full;
    status[3] = ovf;
    status[8 +: AW+1] = level;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      A_CTRL:   rdata = {30'd0, msb, en};
      A_DIV:    rdata = 32'(div);
      A_STATUS: rdata = status;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
      en    <= 1'b0;
      msb   <= 1'b0;
      div   <= DIV_W'(DIV_RST);
      ovf   <= 1'b0;
    end else begin
      ACK_O <= CYC_I & STB_I & ~ACK_O;
      DAT_O <= (acc & ~WE_I) ? rdata : '0;
      if (wr && sel == A_CTRL) begin
        en  <= DAT_I[0];
        msb <= DAT_I[1];
      end
      if (wr && sel == A_DIV) div <= DAT_I[DIV_W-1:0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push_ok) mem[wptr] <= DAT_I[FRAME_W-1:0];
  end

  // Flush wins over a simultaneous push or pop; a popped word is already in shreg.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (!push_ok && pop) level <= level - 1'b1;
    end
  end

  assign cur_bit = msb_lat ? shreg[FRAME_W-1] : shreg[0];

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      divcnt  <= '0;
      div_lat <= '0;
      msb_lat <= 1'b0;
      gapcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg   <= mem[rptr];
            div_lat <= div;
            divcnt  <= div;
            msb_lat <= msb;
            bitcnt  <= BW'(FRAME_W - 1);
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (divcnt == '0) begin
            if (bitcnt == '0) begin
              if (GAP_BITS == 0) begin
                state <= S_IDLE;
              end else begin
                state  <= S_GAP;
                gapcnt <= 4'(GAP_BITS - 1);
                divcnt <= div_lat;
              end
            end else begin
              shreg  <= msb_lat ? (shreg << 1) : (shreg >> 1);
              bitcnt <= bitcnt - 1'b1;
              divcnt <= div_lat;
            end
          end else begin
            divcnt <= divcnt - 1'b1;
          end
        end
        S_GAP: begin
          if (divcnt == '0) begin
            if (gapcnt == '0) begin
              state <= S_IDLE;
            end else begin
              gapcnt <= gapcnt - 1'b1;
              divcnt <= div_lat;
            end
          end else begin
            divcnt <= divcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs trail the FSM by one register stage, so nothing reaches them combinationally.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ena_o  <= 1'b0;
      data_o <= 1'b0;
    end else begin
      ena_o  <= (state == S_SHIFT);
      data_o <= (state == S_SHIFT) & cur_bit;
    end
  end

endmodule
